// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter
//   Sequential binary-to-BCD converter using the shift-and-add-3 method. It
//   runs one add-3/shift iteration per clock, so it needs WIDTH iterations per
//   conversion. There is an optional two's-complement mode that produces a
//   sign flag plus the magnitude.
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous, active-high reset
//   start_i   in   1      request conversion; accepted only while ready_o=1
//   signed_i  in   1      treat bin_i as two's complement; sampled with start_i
//   bin_i     in   WIDTH  value to convert; sampled with start_i
//   ready_o   out  1      idle, a conversion can be accepted
//   busy_o    out  1      shift iterations in progress
//   done_o    out  1      one-cycle pulse: digit outputs updated
//   neg_o     out  1      sign of the last converted value
//   bcd_u_o   out  4      units digit
//   bcd_d_o   out  4      tens digit
//   bcd_c_o   out  4      hundreds digit
module bcd_seq_converter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] bin_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             neg_o,
  output logic [3:0]       bcd_u_o,
  output logic [3:0]       bcd_d_o,
  output logic [3:0]       bcd_c_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   shreg;
  logic [11:0]        scratch;
  logic               sign;

  logic               neg_in;
  logic [WIDTH-1:0]   mag;
  logic [11:0]        adj;
  logic [WIDTH+11:0]  nxt;

  // Magnitude of the incoming operand. The most negative value negates to
  // itself, and that bit pattern is the correct unsigned magnitude.
  always_comb begin
    neg_in = signed_i & bin_i[WIDTH-1];
    mag    = neg_in ? (~bin_i + WIDTH'(1)) : bin_i;
  end

  // One shared add-3 stage per digit. The result is then shifted left by one
  // together with the binary shift register.
  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < 3; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
      end
    end
    nxt = {adj, shreg} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      neg_o   <= 1'b0;
      bcd_u_o <= '0;
      bcd_d_o <= '0;
      bcd_c_o <= '0;
      cnt     <= '0;
      shreg   <= '0;
      scratch <= '0;
      sign    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            shreg   <= mag;
            sign    <= neg_in;
            scratch <= '0;
            cnt     <= '0;
            state   <= SHIFT;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= nxt[WIDTH+11:WIDTH];
          shreg   <= nxt[WIDTH-1:0];
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= DONE;
            busy_o <= 1'b0;
          end
        end
        DONE: begin
          bcd_u_o <= scratch[3:0];
          bcd_d_o <= scratch[7:4];
          bcd_c_o <= scratch[11:8];
          neg_o   <= sign;
          done_o  <= 1'b1;
          state   <= IDLE;
          ready_o <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb_bcd_seq_converter
//   Directed checks of bcd_seq_converter (WIDTH=8). The tests cover the reset
//   state, latency, unsigned and signed results, start held high, reset in the
//   middle of a conversion, and a sweep over all input values in both modes.
module tb_bcd_seq_converter;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic       signed_i;
  logic [7:0] bin_i;
  logic       ready_o;
  logic       busy_o;
  logic       done_o;
  logic       neg_o;
  logic [3:0] bcd_u_o;
  logic [3:0] bcd_d_o;
  logic [3:0] bcd_c_o;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_seq_converter #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .bin_i    (bin_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .neg_o    (neg_o),
    .bcd_u_o  (bcd_u_o),
    .bcd_d_o  (bcd_d_o),
    .bcd_c_o  (bcd_c_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected {neg, hundreds, tens, units}, computed by integer division.
  function automatic logic [12:0] ref_of(input logic [7:0] v, input logic s);
    int m;
    logic n;
    n = s && (v >= 8'd128);
    m = n ? (256 - int'(v)) : int'(v);
    return {n, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [12:0] obs();
    return {neg_o, bcd_c_o, bcd_d_o, bcd_u_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready_o and issues a single start pulse. After acceptance the
  // inputs are scrambled. lat counts the edges from acceptance until done_o
  // is seen.
  task automatic convert(input logic [7:0] v, input logic s, output int lat);
    int k;
    k = 0;
    while (!ready_o && k < 20) begin
      tick();
      k++;
    end
    bin_i    = v;
    signed_i = s;
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
    bin_i    = ~v;
    signed_i = ~s;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done_o && lat < 20);
  endtask

  initial begin
    int lat;
    int ndone;
    int first_e;
    int last_e;
    int gap_bad;
    rst      = 1'b1;
    start_i  = 1'b0;
    signed_i = 1'b0;
    bin_i    = '0;
    repeat (3) tick();

    // Reset state
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy",  32'(busy_o),  32'd0);
    check("rst_done",  32'(done_o),  32'd0);
    check("rst_digits", 32'(obs()), 32'd0);
    rst = 1'b0;
    tick();

    // T1: unsigned 255, latency and one-cycle done pulse
    convert(8'd255, 1'b0, lat);
    check("t1_lat", 32'(lat), 32'd9);
    check("t1_val", 32'(obs()), 32'h0255);
    check("t1_ready", 32'(ready_o), 32'd1);
    tick();
    check("t1_pulse", 32'(done_o), 32'd0);

    // T2: back-to-back conversions
    convert(8'd0, 1'b0, lat);
    check("t2_zero", 32'(obs()), 32'h0000);
    convert(8'd9, 1'b0, lat);
    check("t2_lat", 32'(lat), 32'd9);
    check("t2_nine", 32'(obs()), 32'h0009);

    // T3: signed cases
    convert(8'h80, 1'b1, lat);
    check("t3_min", 32'(obs()), 32'h1128);
    convert(8'hFF, 1'b1, lat);
    check("t3_m1", 32'(obs()), 32'h1001);
    convert(8'h7F, 1'b1, lat);
    check("t3_max", 32'(obs()), 32'h0127);
    convert(8'h00, 1'b1, lat);
    check("t3_zero", 32'(obs()), 32'h0000);

    // T4: start held high. The first acceptance is at edge 1, so done_o is
    // expected after edges 10, 20 and 30.
    bin_i    = 8'd100;
    signed_i = 1'b0;
    start_i  = 1'b1;
    ndone = 0;
    first_e = 0;
    last_e = 0;
    gap_bad = 0;
    for (int e = 1; e <= 31; e++) begin
      tick();
      if (done_o) begin
        ndone++;
        if (first_e == 0) first_e = e;
        else if (e - last_e != 10) gap_bad++;
        last_e = e;
      end
    end
    start_i = 1'b0;
    check("t4_count", 32'(ndone), 32'd3);
    check("t4_first", 32'(first_e), 32'd10);
    check("t4_gap", 32'(gap_bad), 32'd0);
    check("t4_val", 32'(obs()), 32'h0100);
    // This conversion was accepted at edge 31; let it finish.
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done_o && lat < 20);
    check("t4_tail", 32'(done_o), 32'd1);
    check("t4_tail_val", 32'(obs()), 32'h0100);

    // T5: reset in the 4th SHIFT cycle of 200
    tick();
    bin_i   = 8'd200;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    check("t5_busy", 32'(busy_o), 32'd1);
    check("t5_hold", 32'(obs()), 32'h0100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_ready", 32'(ready_o), 32'd1);
    check("t5_busy0", 32'(busy_o), 32'd0);
    check("t5_done0", 32'(done_o), 32'd0);
    check("t5_digits", 32'(obs()), 32'h0000);
    ndone = 0;
    repeat (15) begin
      tick();
      if (done_o) ndone++;
    end
    check("t5_nodone", 32'(ndone), 32'd0);

    // T6: all values in both modes
    for (int sm = 0; sm < 2; sm++) begin
      for (int v = 0; v < 256; v++) begin
        convert(8'(v), 1'(sm), lat);
        check($sformatf("t6_s%0d_v%0d", sm, v), 32'(obs()), 32'(ref_of(8'(v), 1'(sm))));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
